conv_weight_loader: RTL and testbench

- Master side of the conv layer weight-write port (weight_wr_data / weight_wr_addr / weight_wr_en).
- Takes a 32-bit word stream from the host/DMA over a valid/ready handshake.
- Writes the words to consecutive addresses: kernels, then biases, then MACC coefficient, then layer scale.
- One loader per conv instance; it runs once per weight (re)load, before or between frames.

---
 rtl/conv_weight_loader.sv | 137 +++++++++++++
 tb/tb_conv_weight_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_loader.sv
// rtl/conv_weight_loader.sv - weight-write master: streams host words to consecutive conv weight addresses
// Optional feature macro: CONV_WEIGHT_LOADER_CHECKSUM_EN (adds checksum trailer word and checksum/checksum_ok outputs)
module conv_weight_loader #(
  parameter int          KERNEL_0    = 3,
  parameter int          KERNEL_1    = 3,
  parameter int          IN_CHANNEL  = 2,
  parameter int          OUT_CHANNEL = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          NUM_WORDS   = KERNEL_0*KERNEL_1*IN_CHANNEL*OUT_CHANNEL + OUT_CHANNEL + 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum,
  output logic        checksum_ok
`endif
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_wr_data;
  logic [31:0]       r_wr_addr;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;

  logic              w_start_acc;
  logic              w_xfer;
  logic              w_data_xfer;
  logic              w_last;

  assign w_start_acc = (r_state == S_IDLE) & start;
  assign w_xfer      = (r_state == S_LOAD) & s_valid;

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  // Counter parks at NUM_WORDS while waiting for the trailer, which is never written out.
  assign w_data_xfer = w_xfer & (r_count != FULL_IDX);
  assign w_last      = w_xfer & (r_count == FULL_IDX);
`else
  assign w_data_xfer = w_xfer;
  assign w_last      = w_xfer & (r_count == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_LOAD;
      S_LOAD:   if (w_last) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_data_xfer;
      r_done  <= w_last;
      if (w_data_xfer) begin
        r_wr_data <= s_data;
        r_wr_addr <= BASE_ADDR + 32'(r_count);
        r_count   <= r_count + CNT_W'(1);
      end
      if (w_start_acc) begin
        r_busy  <= 1'b1;
        r_count <= '0;
      end else if (w_last) begin
        r_busy  <= 1'b0;
      end
    end
  end

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic        r_checksum_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum    <= '0;
      r_checksum_ok <= 1'b0;
    end else if (w_start_acc) begin
      r_checksum    <= '0;
      r_checksum_ok <= 1'b0;
    end else begin
      if (w_data_xfer) r_checksum <= r_checksum + s_data;
      if (w_last)      r_checksum_ok <= (s_data == r_checksum);
    end
  end

  assign checksum    = r_checksum;
  assign checksum_ok = r_checksum_ok;
`endif

  // s_ready is a pure decode of the state register, so it drops the cycle after the final accept.
  assign s_ready        = (r_state == S_LOAD);
  assign weight_wr_data = r_wr_data;
  assign weight_wr_addr = r_wr_addr;
  assign weight_wr_en   = r_wr_en;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_conv_weight_loader.sv
// tb/tb_conv_weight_loader.sv - directed bench for conv_weight_loader with a transaction-level reference model
module tb_conv_weight_loader;

  localparam int NW = 78;
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;

  logic        ready0, wen0, busy0, done0;
  logic [31:0] data0, addr0;
  logic        ready1, wen1, busy1, done1;
  logic [31:0] data1, addr1;
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] sum0, sum1;
  logic        ok0, ok1;
`endif

  always #5 clk = ~clk;

  conv_weight_loader #(.BASE_ADDR(32'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(ready0), .weight_wr_data(data0), .weight_wr_addr(addr0),
    .weight_wr_en(wen0), .busy(busy0), .done(done0)
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(sum0), .checksum_ok(ok0)
`endif
  );

  conv_weight_loader #(.BASE_ADDR(32'd100)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(ready1), .weight_wr_data(data1), .weight_wr_addr(addr1),
    .weight_wr_en(wen1), .busy(busy1), .done(done1)
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    , .checksum(sum1), .checksum_ok(ok1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is "active" between an accepted start and the final accepted word.
  bit          m_active = 0, m_fin = 0, m_ok = 0;
  bit          was_active, was_fin, acc;
  int          m_count = 0;
  logic [31:0] m_sum = '0;
  bit          e_wen = 0, e_done = 0;
  logic [31:0] e_data = '0, e_addr0 = '0, e_addr1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_fin = 0; m_ok = 0; m_count = 0; m_sum = '0;
      e_wen = 0; e_done = 0; e_data = '0; e_addr0 = '0; e_addr1 = '0;
    end else begin
      was_active = m_active;
      was_fin    = m_fin;
      acc        = was_active && s_valid;
      e_wen  = 0;
      e_done = 0;
      m_fin  = 0;
      if (acc && m_count < NW) begin
        e_wen   = 1;
        e_data  = s_data;
        e_addr0 = 32'(m_count);
        e_addr1 = 32'(100 + m_count);
        m_sum   = m_sum + s_data;
        m_count = m_count + 1;
        if (!CHK && m_count == NW) begin
          m_active = 0; m_fin = 1; e_done = 1;
        end
      end else if (acc) begin
        m_ok = (s_data == m_sum);
        m_active = 0; m_fin = 1; e_done = 1;
      end
      if (!was_active && !was_fin && start) begin
        m_active = 1; m_count = 0; m_sum = '0; m_ok = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready0", ready0, m_active);  chk("ready1", ready1, m_active);
    chk("busy0", busy0, m_active);    chk("busy1", busy1, m_active);
    chk("wen0", wen0, e_wen);         chk("wen1", wen1, e_wen);
    chk("done0", done0, e_done);      chk("done1", done1, e_done);
    chk("data0", data0, e_data);      chk("data1", data1, e_data);
    chk("addr0", addr0, e_addr0);     chk("addr1", addr1, e_addr1);
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    chk("sum0", sum0, m_sum);         chk("sum1", sum1, m_sum);
    chk("ok0", ok0, m_ok);            chk("ok1", ok1, m_ok);
`endif
  end

  // Observer: write counts, contiguity and done placement, checked against literal expectations.
  int          wr_cnt0 = 0, wr_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  logic [31:0] last_addr0 = '0, last_addr1 = '0, first_addr1 = '1;

  always @(negedge clk) begin
    if (wen0) begin
      if (wr_cnt0 > 0) chk("contig0", addr0, last_addr0 + 1);
      chk("data_is_addr_plus1", data0, addr0 + 1);
      last_addr0 = addr0;
      wr_cnt0++;
    end
    if (wen1) begin
      if (wr_cnt1 == 0) first_addr1 = addr1;
      else chk("contig1", addr1, last_addr1 + 1);
      last_addr1 = addr1;
      wr_cnt1++;
    end
    if (done0) begin
      done_cnt0++;
      if (CHK) chk("done_no_wen0", wen0, 0);
      else begin
        chk("done_wen0", wen0, 1);
        chk("done_addr0", addr0, 77);
      end
    end
    if (done1) begin
      done_cnt1++;
      if (!CHK) chk("done_addr1", addr1, 177);
    end
  end

  task automatic clear_obs();
    wr_cnt0 = 0; wr_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0; first_addr1 = '1;
  endtask

  task automatic run_load(input int gap, input logic [31:0] trailer, input int poke, input int abort_at);
    int idx, cyc, phase, total;
    total = CHK ? NW + 1 : NW;
    idx = 0; cyc = 0; phase = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (idx < total && cyc < 3000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      s_valid = (phase == 0);
      phase   = (phase == gap) ? 0 : phase + 1;
      s_data  = (idx < NW) ? 32'(idx + 1) : trailer;
      start   = (idx == poke);
      if (s_valid && ready0) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("load_words", idx, (abort_at >= 0) ? abort_at : total);
  endtask

  task automatic overrun_and_check(input string tag);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (10) begin
      @(posedge clk); #1;
      chk({tag, "_no_ready"}, ready0, 0);
    end
    s_valid = 1'b0;
    chk({tag, "_wr_cnt"}, wr_cnt0, 78);
    chk({tag, "_last_addr"}, last_addr0, 77);
    chk({tag, "_done_cnt"}, done_cnt0, 1);
    chk({tag, "_last_data"}, data0, 78);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready0, 0);
    chk("rst_wen", wen0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ignores_valid", ready0, 0);
    end
    s_valid = 1'b0;

    clear_obs();
    run_load(0, 32'd3081, -1, -1);
    overrun_and_check("basic");
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    chk("cs_good_sum", sum0, 3081);
    chk("cs_good_ok", ok0, 1);
`endif

    clear_obs();
    run_load(2, 32'd3081, -1, -1);
    overrun_and_check("stall");

    clear_obs();
    run_load(0, 32'd3080, 40, -1);
    overrun_and_check("poke40");
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    chk("cs_bad_sum", sum0, 3081);
    chk("cs_bad_ok", ok0, 0);
`endif

    clear_obs();
    run_load(0, 32'd3081, -1, 30);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", wen0, 0);
    chk("midrst_ready", ready0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_addr", addr1, 0);
    chk("midrst_data", data0, 0);
    chk("midrst_writes", wr_cnt0, 30);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_done", done_cnt0, 0);

    clear_obs();
    run_load(0, 32'd3081, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_first_addr", first_addr1, 100);
    chk("restart_last_addr", last_addr1, 177);
    chk("restart_wr_cnt", wr_cnt1, 78);
    chk("restart_done_cnt", done_cnt1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
